// File: rtl/tm1638_board_ctrl_if.sv
// rtl/tm1638_board_ctrl_if.sv - TM1638 3-wire serial bus (STB, CLK, bidirectional DIO split into out/oe/in)
interface tm1638_board_ctrl_if;
  logic sio_stb;
  logic sio_clk;
  logic sio_data_out;
  logic sio_data_oe;
  logic sio_data_in;

  modport master (
    output sio_stb,
    output sio_clk,
    output sio_data_out,
    output sio_data_oe,
    input  sio_data_in
  );

  modport slave (
    input  sio_stb,
    input  sio_clk,
    input  sio_data_out,
    input  sio_data_oe,
    output sio_data_in
  );
endinterface

// File: rtl/tm1638_board_ctrl.sv
// rtl/tm1638_board_ctrl.sv - TM1638 LED&KEY bridge: demuxes scanned 7-seg into a shadow buffer,
// refreshes display/LEDs every frame and reads back the 8 keys
module tm1638_board_ctrl #(
  parameter int CLK_MHZ    = 27,
  parameter int SIO_KHZ    = 1000,
  parameter int BRIGHTNESS = 7
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 led,
  input  logic [7:0]                 abcdefgh,
  input  logic [7:0]                 digit,
  output logic [7:0]                 key,
  tm1638_board_ctrl_if.master        sio
);

  localparam int HALF_RAW = (CLK_MHZ * 1000) / (2 * SIO_KHZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int DW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
  localparam logic [7:0] DISP_CMD = {5'b10001, 3'(BRIGHTNESS)};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD1   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_DISP   = 3'd3;
  localparam logic [2:0] ST_READ   = 3'd4;
  localparam logic [2:0] ST_UPDATE = 3'd5;

  localparam logic [1:0] SUB_BITS = 2'd0;
  localparam logic [1:0] SUB_TURN = 2'd1;
  localparam logic [1:0] SUB_END  = 2'd2;
  localparam logic [1:0] SUB_GAP  = 2'd3;

  logic [2:0]      state;
  logic [1:0]      sub;
  logic [DW-1:0]   div;
  logic [4:0]      byte_idx;
  logic [2:0]      bit_idx;
  logic            phb;
  logic            gap1;
  logic            stb, sclk, dout, oe;
  logic [7:0]      key_next;
  logic [7:0][7:0] shadow, shadow_nxt, frame_seg;
  logic [7:0]      frame_led;

  logic            tick;
  logic            writing;
  logic [3:0]      addr;
  logic [7:0]      seg_sel, seg_rev, tx_byte;
  logic [4:0]      last_byte;
  logic [1:0]      rd_i;

  assign tick    = (state != ST_IDLE) && (div == DIV_LAST);
  assign writing = !((state == ST_READ) && (byte_idx != 5'd0));
  assign rd_i    = byte_idx[1:0] - 2'd1;

  // The snapshot sees this cycle's capture too, so a frame right after reset is never stale
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < 8; i++) begin
      if (digit[i]) shadow_nxt[i] = abcdefgh;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) shadow <= '0;
    else       shadow <= shadow_nxt;
  end

  // Byte k>=1 of DATA is display address k-1; even = digit segments, odd = one LED
  always_comb begin
    addr    = byte_idx[3:0] - 4'd1;
    seg_sel = frame_seg[3'd7 - addr[3:1]];
    for (int j = 0; j < 8; j++) seg_rev[j] = seg_sel[7 - j];
    case (state)
      ST_CMD1: tx_byte = 8'h40;
      ST_DATA: begin
        if (byte_idx == 5'd0)  tx_byte = 8'hC0;
        else if (addr[0])      tx_byte = {7'b0, frame_led[addr[3:1]]};
        else                   tx_byte = seg_rev;
      end
      ST_DISP: tx_byte = DISP_CMD;
      ST_READ: tx_byte = 8'h42;
      default: tx_byte = 8'h00;
    endcase
    case (state)
      ST_DATA: last_byte = 5'd16;
      ST_READ: last_byte = 5'd4;
      default: last_byte = 5'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      sub       <= SUB_BITS;
      div       <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      phb       <= 1'b0;
      gap1      <= 1'b0;
      stb       <= 1'b1;
      sclk      <= 1'b1;
      dout      <= 1'b1;
      oe        <= 1'b0;
      key       <= '0;
      key_next  <= '0;
      frame_seg <= '0;
      frame_led <= '0;
    end else begin
      div <= (state == ST_IDLE || tick) ? '0 : div + DW'(1);
      if (state == ST_IDLE) begin
        frame_seg <= shadow_nxt;
        frame_led <= led;
        state     <= ST_CMD1;
        sub       <= SUB_BITS;
        byte_idx  <= '0;
        bit_idx   <= '0;
        phb       <= 1'b0;
        stb       <= 1'b0;
      end else if (state == ST_UPDATE && sub == SUB_END) begin
        key  <= key_next;
        sub  <= SUB_GAP;
        gap1 <= 1'b0;
      end else if (tick) begin
        case (sub)
          SUB_BITS: begin
            if (!phb) begin
              sclk <= 1'b0;
              phb  <= 1'b1;
              if (writing) begin
                oe   <= 1'b1;
                dout <= tx_byte[bit_idx];
              end
            end else begin
              sclk <= 1'b1;
              phb  <= 1'b0;
              if (!writing) begin
                if (bit_idx == 3'd0) key_next[{1'b0, rd_i}] <= sio.sio_data_in;
                if (bit_idx == 3'd4) key_next[{1'b1, rd_i}] <= sio.sio_data_in;
              end
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                if (byte_idx == last_byte) begin
                  sub <= SUB_END;
                end else begin
                  byte_idx <= byte_idx + 5'd1;
                  if (state == ST_READ && byte_idx == 5'd0) begin
                    sub  <= SUB_TURN;
                    gap1 <= 1'b0;
                  end
                end
              end
            end
          end
          SUB_TURN: begin
            if (!gap1) begin
              oe   <= 1'b0;
              dout <= 1'b1;
              gap1 <= 1'b1;
            end else begin
              sub <= SUB_BITS;
            end
          end
          SUB_END: begin
            stb  <= 1'b1;
            oe   <= 1'b0;
            dout <= 1'b1;
            gap1 <= 1'b0;
            if (state == ST_READ) state <= ST_UPDATE;
            else                  sub   <= SUB_GAP;
          end
          default: begin
            if (!gap1) begin
              gap1 <= 1'b1;
            end else begin
              gap1 <= 1'b0;
              case (state)
                ST_CMD1: state <= ST_DATA;
                ST_DATA: state <= ST_DISP;
                ST_DISP: state <= ST_READ;
                default: state <= ST_IDLE;
              endcase
              if (state != ST_UPDATE) begin
                stb      <= 1'b0;
                sub      <= SUB_BITS;
                byte_idx <= '0;
                bit_idx  <= '0;
                phb      <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  assign sio.sio_stb      = stb;
  assign sio.sio_clk      = sclk;
  assign sio.sio_data_out = dout;
  assign sio.sio_data_oe  = oe;

endmodule
